// File: rtl/alu_seq.sv
// Multi-cycle ALU with iterative multiply/divide, bit-serial shifts,
// registered flags and a valid/ready handshake on both sides.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_data_hi,
    output logic [3:0]       o_flag,
    output logic             o_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_PASS = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_SAR  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_DIVU = 4'hC;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic             sc_q, sc_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [3:0]       flag_q, flag_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w, sub_w, mul_w, div_w;
    logic [WIDTH-1:0] res, res_hi;
    logic             res_c, res_v, res_e;
    logic             in_shift;

    // lo_q doubles as operand A for single-cycle ops
    assign shamt = b_q[SHW-1:0];
    assign add_w = {1'b0, lo_q} + {1'b0, b_q}
                 + {{WIDTH{1'b0}}, cin_q & (op_q == OP_ADC)};
    assign sub_w = {1'b0, lo_q} - {1'b0, b_q}
                 - {{WIDTH{1'b0}}, cin_q & (op_q == OP_SBC)};
    assign mul_w = {1'b0, acc_q}
                 + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};
    assign div_w = {acc_q, lo_q[WIDTH-1]};

    assign in_shift = (i_op == OP_SHL) || (i_op == OP_SHR)
                   || (i_op == OP_SAR);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cin_d   = cin_q;
        sc_d    = sc_q;
        valid_d = valid_q;
        err_d   = err_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        data_d  = data_q;
        hi_d    = hi_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        res     = '0;
        res_hi  = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_e   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = RUN;
                    op_d    = i_op;
                    cin_d   = i_carry;
                    lo_d    = i_data_a;
                    b_d     = i_data_b;
                    sc_d    = 1'b0;
                    acc_d   = in_shift ? i_data_a : '0;
                    cnt_d   = '0;
                    if (in_shift && i_data_b[SHW-1:0] != '0)
                        cnt_d = i_data_b[SHW-1:0] - SHW'(1);
                    if (i_op == OP_MUL
                        || (i_op == OP_DIVU && i_data_b != '0))
                        cnt_d = SHW'(WIDTH - 1);
                end
            end
            RUN: begin
                unique case (op_q)
                    OP_ADD, OP_ADC: begin
                        res   = add_w[WIDTH-1:0];
                        res_c = add_w[WIDTH];
                        res_v = (lo_q[WIDTH-1] == b_q[WIDTH-1])
                             && (res[WIDTH-1] != lo_q[WIDTH-1]);
                    end
                    OP_SUB, OP_SBC: begin
                        res   = sub_w[WIDTH-1:0];
                        res_c = sub_w[WIDTH];
                        res_v = (lo_q[WIDTH-1] != b_q[WIDTH-1])
                             && (res[WIDTH-1] != lo_q[WIDTH-1]);
                    end
                    OP_AND:  res = lo_q & b_q;
                    OP_OR:   res = lo_q | b_q;
                    OP_XOR:  res = lo_q ^ b_q;
                    OP_PASS: res = b_q;
                    OP_SHL, OP_SHR, OP_SAR: begin
                        if (shamt != '0) begin
                            if (op_q == OP_SHL) begin
                                acc_d = {acc_q[WIDTH-2:0], 1'b0};
                                sc_d  = acc_q[WIDTH-1];
                            end else begin
                                acc_d = {((op_q == OP_SAR) && acc_q[WIDTH-1]),
                                         acc_q[WIDTH-1:1]};
                                sc_d  = acc_q[0];
                            end
                        end
                        res   = acc_d;
                        res_c = sc_d;
                    end
                    OP_MUL: begin
                        acc_d  = mul_w[WIDTH:1];
                        lo_d   = {mul_w[0], lo_q[WIDTH-1:1]};
                        res    = lo_d;
                        res_hi = acc_d;
                        res_c  = |acc_d;
                    end
                    OP_DIVU: begin
                        if (b_q == '0) begin
                            res    = '1;
                            res_hi = lo_q;
                            res_e  = 1'b1;
                        end else begin
                            // restoring step: remainder stays below b
                            if (div_w >= {1'b0, b_q}) begin
                                acc_d = div_w[WIDTH-1:0] - b_q;
                                lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_d = div_w[WIDTH-1:0];
                                lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                            end
                            res    = lo_d;
                            res_hi = acc_d;
                        end
                    end
                    default: res_e = 1'b1;
                endcase
                if (cnt_q == '0) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    data_d  = res;
                    hi_d    = res_hi;
                    err_d   = res_e;
                    flag_d  = {res[WIDTH-1], (res == '0), res_c, res_v};
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cin_q   <= 1'b0;
            sc_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            data_q  <= '0;
            hi_q    <= '0;
            flag_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            sc_q    <= sc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_data_hi = hi_q;
    assign o_flag    = flag_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: result table plus handshake,
// backpressure and asynchronous-reset sequences.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid, o_ready, i_carry, o_valid, i_ready, o_err;
    logic [3:0]   i_op, o_flag;
    logic [W-1:0] i_data_a, i_data_b, o_data, o_data_hi;

    int errors = 0;
    int checks = 0;
    int lat;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] d;
        logic [W-1:0] h;
        logic [3:0]   f;
        logic         e;
        int           lat;
    } vec_t;

    vec_t tbl[23];

    alu_seq #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_data_a  (i_data_a),
        .i_data_b  (i_data_b),
        .i_carry   (i_carry),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_data_hi (o_data_hi),
        .o_flag    (o_flag),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // present an op, hold it for the accept edge, then wait for o_valid
    task automatic issue(input vec_t t, output int n);
        @(negedge clk);
        i_op     = t.op;
        i_data_a = t.a;
        i_data_b = t.b;
        i_carry  = t.cin;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        i_op     = 4'h7;
        i_data_a = 16'hDEAD;
        i_data_b = 16'hBEEF;
        i_carry  = 1'b1;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_op(input string nm);
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk({nm, " ready after"}, {31'd0, o_ready}, 32'd1);
        chk({nm, " valid after"}, {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{4'h0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 16'h0000, 4'b0000, 1'b0, 1};
        tbl[1]  = '{4'h2, 16'h0002, 16'h0002, 1'b0, 16'h0000, 16'h0000, 4'b0100, 1'b0, 1};
        tbl[2]  = '{4'h0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0000, 4'b1001, 1'b0, 1};
        tbl[3]  = '{4'h3, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 4'b1010, 1'b0, 1};
        tbl[4]  = '{4'h1, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 16'h0000, 4'b0010, 1'b0, 1};
        tbl[5]  = '{4'h4, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 16'h0000, 4'b0000, 1'b0, 1};
        tbl[6]  = '{4'h5, 16'h8000, 16'h0001, 1'b0, 16'h8001, 16'h0000, 4'b1000, 1'b0, 1};
        tbl[7]  = '{4'h6, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 4'b0100, 1'b0, 1};
        tbl[8]  = '{4'h7, 16'h1234, 16'h8000, 1'b0, 16'h8000, 16'h0000, 4'b1000, 1'b0, 1};
        tbl[9]  = '{4'hB, 16'h1234, 16'h5678, 1'b0, 16'h0060, 16'h0626, 4'b0010, 1'b0, 16};
        tbl[10] = '{4'hC, 16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 4'b0000, 1'b0, 16};
        tbl[11] = '{4'hC, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 4'b1000, 1'b1, 1};
        tbl[12] = '{4'hA, 16'h8000, 16'h0004, 1'b0, 16'hF800, 16'h0000, 4'b1000, 1'b0, 4};
        tbl[13] = '{4'h8, 16'h8001, 16'h0000, 1'b0, 16'h8001, 16'h0000, 4'b1000, 1'b0, 1};
        tbl[14] = '{4'hE, 16'h0005, 16'h0006, 1'b0, 16'h0000, 16'h0000, 4'b0100, 1'b1, 1};
        tbl[15] = '{4'h8, 16'h8001, 16'h0001, 1'b0, 16'h0002, 16'h0000, 4'b0010, 1'b0, 1};
        tbl[16] = '{4'h9, 16'h0003, 16'h0002, 1'b0, 16'h0000, 16'h0000, 4'b0110, 1'b0, 2};
        tbl[17] = '{4'h8, 16'h0001, 16'h000F, 1'b0, 16'h8000, 16'h0000, 4'b1000, 1'b0, 15};
        tbl[18] = '{4'hB, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 4'b0010, 1'b0, 16};
        tbl[19] = '{4'hC, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 4'b1000, 1'b0, 16};
        tbl[20] = '{4'h2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 4'b1010, 1'b0, 1};
        tbl[21] = '{4'h2, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h0000, 4'b0001, 1'b0, 1};
        tbl[22] = '{4'h9, 16'h00F0, 16'hFFF3, 1'b0, 16'h001E, 16'h0000, 4'b0000, 1'b0, 3};

        rst      = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_op     = 4'h0;
        i_data_a = '0;
        i_data_b = '0;
        i_carry  = 1'b0;
        #2;
        chk("reset ready", {31'd0, o_ready}, 32'd1);
        chk("reset valid", {31'd0, o_valid}, 32'd0);
        chk("reset data", {16'd0, o_data}, 32'd0);
        chk("reset hi", {16'd0, o_data_hi}, 32'd0);
        chk("reset flag", {28'd0, o_flag}, 32'd0);
        chk("reset err", {31'd0, o_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            issue(tbl[i], lat);
            chk({nm, " latency"}, lat, tbl[i].lat);
            chk({nm, " data"}, {16'd0, o_data}, {16'd0, tbl[i].d});
            chk({nm, " hi"}, {16'd0, o_data_hi}, {16'd0, tbl[i].h});
            chk({nm, " flag"}, {28'd0, o_flag}, {28'd0, tbl[i].f});
            chk({nm, " err"}, {31'd0, o_err}, {31'd0, tbl[i].e});
            release_op(nm);
        end

        // i_ready already high when o_valid rises: one DONE cycle
        i_ready = 1'b1;
        issue(tbl[0], lat);
        chk("same-edge latency", lat, 1);
        chk("same-edge valid", {31'd0, o_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("same-edge drop", {31'd0, o_valid}, 32'd0);
        chk("same-edge ready", {31'd0, o_ready}, 32'd1);
        i_ready = 1'b0;

        // backpressure: MUL 3*5 with stray i_valid during RUN and DONE
        @(negedge clk);
        i_op     = 4'hB;
        i_data_a = 16'h0003;
        i_data_b = 16'h0005;
        i_carry  = 1'b0;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_op     = 4'h0;
        i_data_a = 16'h1111;
        i_data_b = 16'h2222;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            i_valid = lat[0];
        end
        i_valid = 1'b1;
        chk("bp latency", lat, 16);
        chk("bp data", {16'd0, o_data}, 32'h000F);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d valid", k), {31'd0, o_valid}, 32'd1);
            chk($sformatf("bp hold%0d data", k), {16'd0, o_data}, 32'h000F);
            chk($sformatf("bp hold%0d hi", k), {16'd0, o_data_hi}, 32'd0);
            chk($sformatf("bp hold%0d flag", k), {28'd0, o_flag}, 32'd0);
            chk($sformatf("bp hold%0d ready", k), {31'd0, o_ready}, 32'd0);
        end
        i_valid = 1'b0;
        release_op("bp");
        repeat (2) @(posedge clk);
        #1;
        chk("bp no stray op", {31'd0, o_valid}, 32'd0);

        // asynchronous reset in the middle of a MUL
        @(negedge clk);
        i_op     = 4'hB;
        i_data_a = 16'h1234;
        i_data_b = 16'h5678;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid rst ready", {31'd0, o_ready}, 32'd1);
        chk("mid rst valid", {31'd0, o_valid}, 32'd0);
        chk("mid rst data", {16'd0, o_data}, 32'd0);
        chk("mid rst hi", {16'd0, o_data_hi}, 32'd0);
        chk("mid rst flag", {28'd0, o_flag}, 32'd0);
        chk("mid rst err", {31'd0, o_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(tbl[2], lat);
        chk("post rst latency", lat, 1);
        chk("post rst data", {16'd0, o_data}, 32'h8000);
        chk("post rst flag", {28'd0, o_flag}, 32'h9);
        release_op("post rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the nlp16af datapath: the multi-cycle successor to the combinational ALU. It adds configurable width, iterative unsigned multiply and divide, multi-bit shifts, registered flags and a valid/ready handshake. It sits between the register-file read stage and write-back. The sequencer issues one operation and stalls on `o_ready` until the result is accepted.

## Interface
- `WIDTH`, default 16: data path width; must be at least 4 and a power of two.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `i_clk`, in, 1: clock; all state is updated on its rising edge.
- `i_rst`, in, 1: reset, asynchronous and active-high.
- `i_valid`, in, 1: an operation is presented.
- `o_ready`, out, 1: the block can accept an operation (state IDLE).
- `i_op`, in, 4: operation code.
- `i_data_a`, in, WIDTH: operand A.
- `i_data_b`, in, WIDTH: operand B; bits `[SHW-1:0]` are the shift amount for shift ops.
- `i_carry`, in, 1: carry-in, used by ADC and SBC.
- `o_valid`, out, 1: result registers hold a completed result.
- `i_ready`, in, 1: the consumer accepts the result.
- `o_data`, out, WIDTH: primary result.
- `o_data_hi`, out, WIDTH: MUL high half or DIVU remainder; 0 for all other ops.
- `o_flag`, out, 4: `{S, Z, C, V}`, i.e. bit 3 is sign, bit 0 is overflow.
- `o_err`, out, 1: divide-by-zero or reserved opcode.

## Operation
- Opcodes:
  - 0x0 ADD: a+b.
  - 0x1 ADC: a+b+carry.
  - 0x2 SUB: a-b.
  - 0x3 SBC: a-b-carry.
  - 0x4 AND.
  - 0x5 OR.
  - 0x6 XOR.
  - 0x7 PASSB.
  - 0x8 SHL, 0x9 SHR (logical), 0xA SAR: shift a by `s = b[SHW-1:0]`.
  - 0xB MUL: unsigned a×b, 2·WIDTH-bit product.
  - 0xC DIVU: unsigned a÷b.
  - 0xD–0xF: reserved.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `i_valid & o_ready`. Operands, op and carry are captured into internal registers; later input changes are ignored.
  - RUN → DONE when the iteration counter expires. Result and flag registers load on that edge and `o_valid` rises.
  - DONE → IDLE on `i_ready`. Results stay held and `o_valid` falls on that edge.
  - No acceptance happens while in DONE, so at most one operation is outstanding.
- Result rules:
  - Arithmetic wraps modulo 2^WIDTH.
  - Single-cycle ops (0x0–0x7) complete in one RUN cycle.
  - Shifts move one bit per RUN cycle, s cycles in total, minimum 1 cycle when s=0.
  - MUL is shift-add, one bit per cycle, WIDTH cycles. `o_data` gets the low half of the product and `o_data_hi` the high half.
  - DIVU is restoring division, WIDTH cycles. `o_data` = quotient, `o_data_hi` = remainder.
  - DIVU with b=0 takes 1 cycle: `o_data` = all-ones, `o_data_hi` = a, `o_err` = 1.
  - Reserved opcodes take 1 cycle: `o_data` = 0, `o_data_hi` = 0, `o_err` = 1, flags computed normally on the zero result (Z=1).
- Flags are computed from the final `o_data`:
  - S = `o_data[WIDTH-1]`.
  - Z = (`o_data` == 0).
  - C:
    - ADD/ADC: carry-out.
    - SUB/SBC: borrow (1 when the unsigned result underflows).
    - Shifts: last bit shifted out; 0 when s=0.
    - MUL: 1 when the high half is nonzero.
    - All other ops: 0.
  - V: signed overflow for ADD/ADC/SUB/SBC; 0 for all other ops.

## Timing
- Reset (asynchronous, immediate, including mid-RUN): state IDLE, `o_ready`=1, `o_valid`=0, and `o_data`, `o_data_hi`, `o_flag`, `o_err` all 0. Any partial operation is discarded.
- `o_ready` is decoded combinationally from state (state==IDLE). It falls the cycle after acceptance.
- Latency, counted from the accept edge to the edge on which `o_valid` rises:
  - Ops 0x0–0x7, DIVU-by-zero and reserved opcodes: 1 cycle.
  - Shifts: max(1, s) cycles.
  - MUL and DIVU: WIDTH cycles.
- `o_valid` and all result outputs are registered and stay stable while in DONE, for any length of `i_ready` backpressure.
- `i_ready` high on the same edge `o_valid` rises has no effect. It is honoured from the first DONE cycle onward, so the minimum DONE dwell is 1 cycle.
- The next operation can be accepted on the edge after DONE → IDLE, so the minimum issue interval is latency + 2 cycles.
- `i_valid` while `o_ready`=0 is ignored; the producer must hold it until it is accepted.

## Test plan
- ADD a=0x0001, b=0x0002 → `o_data`=0x0003, flags 0000, `o_valid` 1 cycle after accept. SUB a=0x0002, b=0x0002 → 0x0000, Z=1, C=0.
- ADD 0x7FFF+0x0001 → 0x8000, S=1, V=1, C=0. SBC 0x0000−0x0000 with carry=1 → 0xFFFF, S=1, C=1.
- MUL 0x1234×0x5678 → `o_data_hi`=0x0626, `o_data`=0x0060, C=1, `o_valid` exactly 16 cycles after accept.
- DIVU 0x0064÷0x0007 → quotient 0x000E, remainder 0x0002, 16 cycles. DIVU 0x1234÷0 → 0xFFFF / 0x1234, `o_err`=1, 1 cycle.
- SAR 0x8000 by 4 → 0xF800, S=1, C=0, 4 cycles. SHL 0x8001 by 0 → 0x8001, C=0, 1 cycle. Opcode 0xE → 0x0000, Z=1, `o_err`=1.
- Backpressure and reset:
  - Hold `i_ready` low for 5 cycles after `o_valid` → all outputs stable; `i_valid` pulses during RUN are ignored.
  - Assert `i_rst` mid-MUL (cycle 5) → all outputs 0 and `o_ready`=1 immediately; a fresh ADD afterwards completes correctly.
